// File: rtl/deep_ff_cmd_sequencer_if.sv
// Command/issue bundle between the operand producer, the sequencer and the
// downstream deep flip-flop ALU stage.
interface deep_ff_cmd_sequencer_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             dfcs_in_valid;
   logic             dfcs_in_ready;
   logic [3:0]       dfcs_in_mode;
   logic [15:0]      dfcs_in_a;
   logic [15:0]      dfcs_in_b;
   logic             dfcs_pause;
   logic             dfcs_flush;
   logic [3:0]       dfcs_ctrl_mode;
   logic [15:0]      dfcs_data_in1;
   logic [15:0]      dfcs_data_in2;
   logic             dfcs_issue_valid;
   logic [TAG_W-1:0] dfcs_issue_tag;
   logic [CNT_W-1:0] dfcs_count;

   modport master (
      output dfcs_in_valid,
      input  dfcs_in_ready,
      output dfcs_in_mode,
      output dfcs_in_a,
      output dfcs_in_b,
      output dfcs_pause,
      output dfcs_flush,
      input  dfcs_ctrl_mode,
      input  dfcs_data_in1,
      input  dfcs_data_in2,
      input  dfcs_issue_valid,
      input  dfcs_issue_tag,
      input  dfcs_count
   );

   modport slave (
      input  dfcs_in_valid,
      output dfcs_in_ready,
      input  dfcs_in_mode,
      input  dfcs_in_a,
      input  dfcs_in_b,
      input  dfcs_pause,
      input  dfcs_flush,
      output dfcs_ctrl_mode,
      output dfcs_data_in1,
      output dfcs_data_in2,
      output dfcs_issue_valid,
      output dfcs_issue_tag,
      output dfcs_count
   );
endinterface

// File: rtl/deep_ff_cmd_sequencer.sv
// Command FIFO and issue stage feeding the deep flip-flop ALU stage: buffers
// {mode, A, B}, issues one tagged command per cycle, supports pause and flush.
module deep_ff_cmd_sequencer #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned TAG_W     = 4,
   parameter logic [3:0]  IDLE_MODE = 4'hF
) (
   input  logic                   dfcs_clk,
   input  logic                   dfcs_rst,
   deep_ff_cmd_sequencer_if.slave dfcs_bus
);
   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned CNT_W   = AW + 1;
   localparam int unsigned ENTRY_W = 4 + 16 + 16;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_PAUSE = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic [TAG_W-1:0]   r_tag_cnt;
   logic [TAG_W-1:0]   r_issue_tag;
   logic [3:0]         r_ctrl_mode;
   logic [15:0]        r_data1;
   logic [15:0]        r_data2;
   logic               r_issue_valid;

   logic               w_in_ready;
   logic               w_push;
   logic               w_pop;
   logic [ENTRY_W-1:0] w_head;

   always_ff @(posedge dfcs_clk) begin
      if (dfcs_rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Flush outranks pause from every state; FLUSH lasts exactly one cycle.
   always_comb begin
      w_state_next = r_state;
      if (dfcs_bus.dfcs_flush) begin
         w_state_next = ST_FLUSH;
      end else begin
         unique case (r_state)
            ST_RUN:   if (dfcs_bus.dfcs_pause) w_state_next = ST_PAUSE;
            ST_PAUSE: if (!dfcs_bus.dfcs_pause) w_state_next = ST_RUN;
            ST_FLUSH: w_state_next = dfcs_bus.dfcs_pause ? ST_PAUSE : ST_RUN;
            default:  w_state_next = ST_RUN;
         endcase
      end
   end

   always_comb begin
      w_in_ready = (r_count < FULL_CNT) && !dfcs_bus.dfcs_flush && (r_state != ST_FLUSH);
      w_push     = dfcs_bus.dfcs_in_valid && w_in_ready;
      w_pop      = (r_state == ST_RUN) && !dfcs_bus.dfcs_pause && !dfcs_bus.dfcs_flush
                   && (r_count != '0);
      w_head     = r_mem[r_rd_ptr];
   end

   always_ff @(posedge dfcs_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {dfcs_bus.dfcs_in_mode, dfcs_bus.dfcs_in_a, dfcs_bus.dfcs_in_b};
      end
   end

   always_ff @(posedge dfcs_clk) begin
      if (dfcs_rst || dfcs_bus.dfcs_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Issue register: loads the head on a pop, otherwise drives a bubble.
   always_ff @(posedge dfcs_clk) begin
      if (dfcs_rst) begin
         r_ctrl_mode   <= IDLE_MODE;
         r_data1       <= '0;
         r_data2       <= '0;
         r_issue_valid <= 1'b0;
         r_issue_tag   <= '0;
         r_tag_cnt     <= '0;
      end else if (w_pop) begin
         r_ctrl_mode   <= w_head[35:32];
         r_data1       <= w_head[31:16];
         r_data2       <= w_head[15:0];
         r_issue_valid <= 1'b1;
         r_issue_tag   <= r_tag_cnt;
         r_tag_cnt     <= r_tag_cnt + TAG_W'(1);
      end else begin
         r_ctrl_mode   <= IDLE_MODE;
         r_data1       <= '0;
         r_data2       <= '0;
         r_issue_valid <= 1'b0;
      end
   end

   assign dfcs_bus.dfcs_in_ready    = w_in_ready;
   assign dfcs_bus.dfcs_ctrl_mode   = r_ctrl_mode;
   assign dfcs_bus.dfcs_data_in1    = r_data1;
   assign dfcs_bus.dfcs_data_in2    = r_data2;
   assign dfcs_bus.dfcs_issue_valid = r_issue_valid;
   assign dfcs_bus.dfcs_issue_tag   = r_issue_tag;
   assign dfcs_bus.dfcs_count       = r_count;
endmodule

// File: tb/tb_deep_ff_cmd_sequencer.sv
// Directed self-checking bench for deep_ff_cmd_sequencer (DEPTH=4, TAG_W=4).
module tb_deep_ff_cmd_sequencer;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   deep_ff_cmd_sequencer_if #(.DEPTH(4), .TAG_W(4)) bus ();

   deep_ff_cmd_sequencer #(
      .DEPTH     (4),
      .TAG_W     (4),
      .IDLE_MODE (4'hF)
   ) dut (
      .dfcs_clk (clk),
      .dfcs_rst (rst),
      .dfcs_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] m, input logic [15:0] a,
                        input logic [15:0] b);
      bus.dfcs_in_valid = v;
      bus.dfcs_in_mode  = m;
      bus.dfcs_in_a     = a;
      bus.dfcs_in_b     = b;
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.dfcs_pause = 1'b0;
      bus.dfcs_flush = 1'b0;
      drive(1'b0, 4'h0, 16'h0, 16'h0);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.dfcs_pause = 1'b0;
      bus.dfcs_flush = 1'b0;
      drive(1'b0, 4'h0, 16'h0, 16'h0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_checks++; if (bus.dfcs_ctrl_mode !== 4'hF) begin n_errors++; $display("FAIL reset_mode: got %h expected f", bus.dfcs_ctrl_mode); end
      n_checks++; if (bus.dfcs_data_in1 !== 16'h0) begin n_errors++; $display("FAIL reset_d1: got %h expected 0", bus.dfcs_data_in1); end
      n_checks++; if (bus.dfcs_data_in2 !== 16'h0) begin n_errors++; $display("FAIL reset_d2: got %h expected 0", bus.dfcs_data_in2); end
      n_checks++; if (bus.dfcs_issue_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", bus.dfcs_issue_valid); end
      n_checks++; if (bus.dfcs_issue_tag !== 4'h0) begin n_errors++; $display("FAIL reset_tag: got %h expected 0", bus.dfcs_issue_tag); end
      n_checks++; if (bus.dfcs_count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", bus.dfcs_count); end
      n_checks++; if (bus.dfcs_in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", bus.dfcs_in_ready); end
   endtask

   task automatic test_single();
      drive(1'b1, 4'h0, 16'h0003, 16'h0004);
      n_checks++; if (bus.dfcs_in_ready !== 1'b1) begin n_errors++; $display("FAIL single_ready: got %b expected 1", bus.dfcs_in_ready); end
      tick();
      drive(1'b0, 4'h0, 16'h0, 16'h0);
      n_checks++; if (bus.dfcs_issue_valid !== 1'b0) begin n_errors++; $display("FAIL single_no_bypass: got %b expected 0", bus.dfcs_issue_valid); end
      n_checks++; if (bus.dfcs_count !== 3'd1) begin n_errors++; $display("FAIL single_count1: got %0d expected 1", bus.dfcs_count); end
      tick();
      n_checks++; if (bus.dfcs_issue_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b expected 1", bus.dfcs_issue_valid); end
      n_checks++; if (bus.dfcs_ctrl_mode !== 4'h0) begin n_errors++; $display("FAIL single_mode: got %h expected 0", bus.dfcs_ctrl_mode); end
      n_checks++; if (bus.dfcs_data_in1 !== 16'h0003) begin n_errors++; $display("FAIL single_d1: got %h expected 0003", bus.dfcs_data_in1); end
      n_checks++; if (bus.dfcs_data_in2 !== 16'h0004) begin n_errors++; $display("FAIL single_d2: got %h expected 0004", bus.dfcs_data_in2); end
      n_checks++; if (bus.dfcs_issue_tag !== 4'h0) begin n_errors++; $display("FAIL single_tag: got %h expected 0", bus.dfcs_issue_tag); end
      n_checks++; if (bus.dfcs_count !== 3'd0) begin n_errors++; $display("FAIL single_count0: got %0d expected 0", bus.dfcs_count); end
      tick();
      n_checks++; if (bus.dfcs_issue_valid !== 1'b0) begin n_errors++; $display("FAIL single_bubble_valid: got %b expected 0", bus.dfcs_issue_valid); end
      n_checks++; if (bus.dfcs_ctrl_mode !== 4'hF) begin n_errors++; $display("FAIL single_bubble_mode: got %h expected f", bus.dfcs_ctrl_mode); end
      n_checks++; if (bus.dfcs_data_in1 !== 16'h0 || bus.dfcs_data_in2 !== 16'h0) begin n_errors++; $display("FAIL single_bubble_data: got %h/%h expected 0/0", bus.dfcs_data_in1, bus.dfcs_data_in2); end
   endtask

   task automatic test_pause_full();
      logic       exp_rdy;
      logic [2:0] exp_cnt;
      do_reset();
      bus.dfcs_pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'(i + 1), 16'h0100 + 16'(i), 16'h0200 + 16'(i));
         exp_rdy = (i < 4);
         n_checks++; if (bus.dfcs_in_ready !== exp_rdy) begin n_errors++; $display("FAIL pause_ready_%0d: got %b expected %b", i, bus.dfcs_in_ready, exp_rdy); end
         if (i < 4) tick();
      end
      n_checks++; if (bus.dfcs_count !== 3'd4) begin n_errors++; $display("FAIL pause_count_full: got %0d expected 4", bus.dfcs_count); end
      n_checks++; if (bus.dfcs_issue_valid !== 1'b0) begin n_errors++; $display("FAIL pause_no_issue: got %b expected 0", bus.dfcs_issue_valid); end
      bus.dfcs_pause = 1'b0;
      #1;
      tick();
      n_checks++; if (bus.dfcs_issue_valid !== 1'b0) begin n_errors++; $display("FAIL pause_exit_bubble: got %b expected 0", bus.dfcs_issue_valid); end
      n_checks++; if (bus.dfcs_count !== 3'd4) begin n_errors++; $display("FAIL pause_exit_count: got %0d expected 4", bus.dfcs_count); end
      for (int k = 0; k < 5; k++) begin
         if (k == 0) begin
            n_checks++; if (bus.dfcs_in_ready !== 1'b0) begin n_errors++; $display("FAIL pause_ready_before_pop: got %b expected 0", bus.dfcs_in_ready); end
         end
         tick();
         if (k == 0) begin
            n_checks++; if (bus.dfcs_in_ready !== 1'b1) begin n_errors++; $display("FAIL pause_ready_after_pop: got %b expected 1", bus.dfcs_in_ready); end
         end
         if (k == 1) drive(1'b0, 4'h0, 16'h0, 16'h0);
         exp_cnt = (k == 0) ? 3'd3 : 3'(4 - k);
         n_checks++; if (bus.dfcs_issue_valid !== 1'b1) begin n_errors++; $display("FAIL pause_issue_valid_%0d: got %b expected 1", k, bus.dfcs_issue_valid); end
         n_checks++; if (bus.dfcs_ctrl_mode !== 4'(k + 1)) begin n_errors++; $display("FAIL pause_issue_mode_%0d: got %h expected %h", k, bus.dfcs_ctrl_mode, 4'(k + 1)); end
         n_checks++; if (bus.dfcs_data_in1 !== 16'h0100 + 16'(k)) begin n_errors++; $display("FAIL pause_issue_d1_%0d: got %h expected %h", k, bus.dfcs_data_in1, 16'h0100 + 16'(k)); end
         n_checks++; if (bus.dfcs_data_in2 !== 16'h0200 + 16'(k)) begin n_errors++; $display("FAIL pause_issue_d2_%0d: got %h expected %h", k, bus.dfcs_data_in2, 16'h0200 + 16'(k)); end
         n_checks++; if (bus.dfcs_issue_tag !== 4'(k)) begin n_errors++; $display("FAIL pause_issue_tag_%0d: got %h expected %h", k, bus.dfcs_issue_tag, 4'(k)); end
         n_checks++; if (bus.dfcs_count !== exp_cnt) begin n_errors++; $display("FAIL pause_issue_count_%0d: got %0d expected %0d", k, bus.dfcs_count, exp_cnt); end
      end
   endtask

   task automatic test_back_to_back();
      int         j;
      logic [2:0] exp_cnt;
      do_reset();
      for (int i = 0; i <= 20; i++) begin
         if (i < 20) begin
            drive(1'b1, 4'(i), 16'(i * 3 + 1), 16'hF000 ^ 16'(i));
            n_checks++; if (bus.dfcs_in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, bus.dfcs_in_ready); end
         end else begin
            drive(1'b0, 4'h0, 16'h0, 16'h0);
         end
         tick();
         exp_cnt = (i < 20) ? 3'd1 : 3'd0;
         n_checks++; if (bus.dfcs_count !== exp_cnt) begin n_errors++; $display("FAIL b2b_count_%0d: got %0d expected %0d", i, bus.dfcs_count, exp_cnt); end
         if (i >= 1) begin
            j = i - 1;
            n_checks++; if (bus.dfcs_issue_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid_%0d: got %b expected 1", j, bus.dfcs_issue_valid); end
            n_checks++; if (bus.dfcs_ctrl_mode !== 4'(j)) begin n_errors++; $display("FAIL b2b_mode_%0d: got %h expected %h", j, bus.dfcs_ctrl_mode, 4'(j)); end
            n_checks++; if (bus.dfcs_data_in1 !== 16'(j * 3 + 1)) begin n_errors++; $display("FAIL b2b_d1_%0d: got %h expected %h", j, bus.dfcs_data_in1, 16'(j * 3 + 1)); end
            n_checks++; if (bus.dfcs_data_in2 !== (16'hF000 ^ 16'(j))) begin n_errors++; $display("FAIL b2b_d2_%0d: got %h expected %h", j, bus.dfcs_data_in2, 16'hF000 ^ 16'(j)); end
            n_checks++; if (bus.dfcs_issue_tag !== 4'(j % 16)) begin n_errors++; $display("FAIL b2b_tag_%0d: got %h expected %h", j, bus.dfcs_issue_tag, 4'(j % 16)); end
         end
      end
   endtask

   // Runs straight after test_back_to_back: the tag counter sits at 20 mod 16 = 4.
   task automatic test_flush();
      bus.dfcs_pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'hA, 16'h0A00 + 16'(i), 16'h0B00 + 16'(i));
         tick();
      end
      drive(1'b0, 4'h0, 16'h0, 16'h0);
      n_checks++; if (bus.dfcs_count !== 3'd3) begin n_errors++; $display("FAIL flush_precount: got %0d expected 3", bus.dfcs_count); end
      bus.dfcs_flush = 1'b1;
      drive(1'b1, 4'h7, 16'hDEAD, 16'hBEEF);
      n_checks++; if (bus.dfcs_in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b expected 0", bus.dfcs_in_ready); end
      tick();
      n_checks++; if (bus.dfcs_count !== 3'd0) begin n_errors++; $display("FAIL flush_count: got %0d expected 0", bus.dfcs_count); end
      n_checks++; if (bus.dfcs_issue_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b expected 0", bus.dfcs_issue_valid); end
      n_checks++; if (bus.dfcs_ctrl_mode !== 4'hF) begin n_errors++; $display("FAIL flush_mode: got %h expected f", bus.dfcs_ctrl_mode); end
      bus.dfcs_flush = 1'b0;
      bus.dfcs_pause = 1'b0;
      #1;
      n_checks++; if (bus.dfcs_in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_state_ready: got %b expected 0", bus.dfcs_in_ready); end
      tick();
      n_checks++; if (bus.dfcs_count !== 3'd0) begin n_errors++; $display("FAIL flush_state_count: got %0d expected 0", bus.dfcs_count); end
      drive(1'b1, 4'h2, 16'h1234, 16'h5678);
      n_checks++; if (bus.dfcs_in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_after_ready: got %b expected 1", bus.dfcs_in_ready); end
      tick();
      drive(1'b0, 4'h0, 16'h0, 16'h0);
      tick();
      n_checks++; if (bus.dfcs_issue_valid !== 1'b1) begin n_errors++; $display("FAIL flush_after_valid: got %b expected 1", bus.dfcs_issue_valid); end
      n_checks++; if (bus.dfcs_ctrl_mode !== 4'h2 || bus.dfcs_data_in1 !== 16'h1234 || bus.dfcs_data_in2 !== 16'h5678) begin n_errors++; $display("FAIL flush_after_data: got %h/%h/%h expected 2/1234/5678", bus.dfcs_ctrl_mode, bus.dfcs_data_in1, bus.dfcs_data_in2); end
      n_checks++; if (bus.dfcs_issue_tag !== 4'h4) begin n_errors++; $display("FAIL flush_after_tag: got %h expected 4", bus.dfcs_issue_tag); end
   endtask

   task automatic test_reset_midop();
      bus.dfcs_pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'h3, 16'h0300 + 16'(i), 16'h0330 + 16'(i));
         tick();
      end
      drive(1'b0, 4'h0, 16'h0, 16'h0);
      bus.dfcs_pause = 1'b0;
      #1;
      tick();
      tick();
      n_checks++; if (bus.dfcs_issue_valid !== 1'b1 || bus.dfcs_data_in1 !== 16'h0300) begin n_errors++; $display("FAIL midrst_pre_issue: got %b/%h expected 1/0300", bus.dfcs_issue_valid, bus.dfcs_data_in1); end
      n_checks++; if (bus.dfcs_count !== 3'd2) begin n_errors++; $display("FAIL midrst_pre_count: got %0d expected 2", bus.dfcs_count); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (bus.dfcs_issue_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b expected 0", bus.dfcs_issue_valid); end
      n_checks++; if (bus.dfcs_ctrl_mode !== 4'hF) begin n_errors++; $display("FAIL midrst_mode: got %h expected f", bus.dfcs_ctrl_mode); end
      n_checks++; if (bus.dfcs_data_in1 !== 16'h0 || bus.dfcs_data_in2 !== 16'h0) begin n_errors++; $display("FAIL midrst_data: got %h/%h expected 0/0", bus.dfcs_data_in1, bus.dfcs_data_in2); end
      n_checks++; if (bus.dfcs_count !== 3'd0) begin n_errors++; $display("FAIL midrst_count: got %0d expected 0", bus.dfcs_count); end
      n_checks++; if (bus.dfcs_issue_tag !== 4'h0) begin n_errors++; $display("FAIL midrst_tag: got %h expected 0", bus.dfcs_issue_tag); end
      tick();
      n_checks++; if (bus.dfcs_issue_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_dropped: got %b expected 0", bus.dfcs_issue_valid); end
      drive(1'b1, 4'h6, 16'h0606, 16'h0660);
      tick();
      drive(1'b0, 4'h0, 16'h0, 16'h0);
      tick();
      n_checks++; if (bus.dfcs_issue_valid !== 1'b1 || bus.dfcs_data_in1 !== 16'h0606) begin n_errors++; $display("FAIL midrst_next_issue: got %b/%h expected 1/0606", bus.dfcs_issue_valid, bus.dfcs_data_in1); end
      n_checks++; if (bus.dfcs_issue_tag !== 4'h0) begin n_errors++; $display("FAIL midrst_next_tag: got %h expected 0", bus.dfcs_issue_tag); end
   endtask

   // Tag counter is 1 here after the single post-reset issue above.
   task automatic test_full_pop();
      logic [2:0] exp_cnt;
      bus.dfcs_pause = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'h8, 16'h0800 + 16'(i), 16'h0880 + 16'(i));
         tick();
      end
      drive(1'b1, 4'h9, 16'h0999, 16'h0990);
      n_checks++; if (bus.dfcs_count !== 3'd4) begin n_errors++; $display("FAIL full_count: got %0d expected 4", bus.dfcs_count); end
      bus.dfcs_pause = 1'b0;
      #1;
      tick();
      n_checks++; if (bus.dfcs_in_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready_pop_cycle: got %b expected 0", bus.dfcs_in_ready); end
      for (int k = 0; k < 5; k++) begin
         tick();
         if (k == 0) begin
            n_checks++; if (bus.dfcs_in_ready !== 1'b1) begin n_errors++; $display("FAIL full_ready_after_pop: got %b expected 1", bus.dfcs_in_ready); end
         end
         if (k == 1) drive(1'b0, 4'h0, 16'h0, 16'h0);
         exp_cnt = (k == 0) ? 3'd3 : 3'(4 - k);
         n_checks++; if (bus.dfcs_count !== exp_cnt) begin n_errors++; $display("FAIL full_count_%0d: got %0d expected %0d", k, bus.dfcs_count, exp_cnt); end
         n_checks++; if (bus.dfcs_issue_tag !== 4'(k + 1)) begin n_errors++; $display("FAIL full_tag_%0d: got %h expected %h", k, bus.dfcs_issue_tag, 4'(k + 1)); end
         if (k < 4) begin
            n_checks++; if (bus.dfcs_issue_valid !== 1'b1 || bus.dfcs_ctrl_mode !== 4'h8 || bus.dfcs_data_in1 !== 16'h0800 + 16'(k)) begin n_errors++; $display("FAIL full_issue_%0d: got %b/%h/%h expected 1/8/%h", k, bus.dfcs_issue_valid, bus.dfcs_ctrl_mode, bus.dfcs_data_in1, 16'h0800 + 16'(k)); end
         end else begin
            n_checks++; if (bus.dfcs_issue_valid !== 1'b1 || bus.dfcs_ctrl_mode !== 4'h9 || bus.dfcs_data_in1 !== 16'h0999 || bus.dfcs_data_in2 !== 16'h0990) begin n_errors++; $display("FAIL full_held_cmd: got %b/%h/%h/%h expected 1/9/0999/0990", bus.dfcs_issue_valid, bus.dfcs_ctrl_mode, bus.dfcs_data_in1, bus.dfcs_data_in2); end
         end
      end
   endtask

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      rst            = 1'b1;
      bus.dfcs_pause = 1'b0;
      bus.dfcs_flush = 1'b0;
      bus.dfcs_in_valid = 1'b0;
      bus.dfcs_in_mode  = 4'h0;
      bus.dfcs_in_a     = 16'h0;
      bus.dfcs_in_b     = 16'h0;
      test_reset();
      test_single();
      test_pause_full();
      test_back_to_back();
      test_flush();
      test_reset_midop();
      test_full_pop();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1);
   end
endmodule
